usb_rx_ctrl: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 31 +++
 rtl/usb_rx_ctrl_bit_counter.sv | 34 +++
 rtl/usb_rx_ctrl.sv | 118 +++++++++++
 tb/tb_usb_rx_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive control unit
package usb_rx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CHK_SYNC,
        ST_PID,
        ST_CHK_PID,
        ST_DATA,
        ST_STORE,
        ST_EOP_WAIT,
        ST_ERR,
        ST_ERR_IDLE
    } rx_state_t;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

    // A PID byte carries its type nibble followed by the nibble's complement.
    function automatic logic pid_ok(input logic [7:0] b);
        return b[3:0] == ~b[7:4];
    endfunction

endpackage

// File: rtl/usb_rx_ctrl_bit_counter.sv
// rtl/usb_rx_ctrl_bit_counter.sv - 3-bit sample counter framing bytes from shift strobes
module rx_bit_counter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear_i,
    input  logic       enable_i,
    output logic [2:0] count_o,
    output logic       byte_done_o
);

    logic [2:0] count_q, count_d;

    // Wraps from 7 to 0 on its own, so each completed byte restarts the count.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 3'd0;
        end else if (enable_i) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign byte_done_o = enable_i && (count_q == 3'd7);

endmodule

// File: rtl/usb_rx_ctrl.sv
// rtl/usb_rx_ctrl.sv - USB bulk receive sequencer; RX_BYTE_COUNT_EN adds the byte_cnt output
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_BYTES = 64,
    parameter int         CNT_W     = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             shift_enable,
    input  logic             eop,
    input  logic [7:0]       rcv_data,
    input  logic             fifo_full,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic [3:0]       rx_pid,
    output logic             pkt_done
`ifdef RX_BYTE_COUNT_EN
    ,
    output logic [CNT_W-1:0] byte_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    rx_state_t        state_q, state_d;
    logic [3:0]       rx_pid_q, rx_pid_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             pkt_done_q, pkt_done_d;
    logic [2:0]       bit_cnt;
    logic             byte_done;
    logic             bit_clear;
    logic             idle_like;
    logic             store_ok;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_ERR_IDLE);
    assign bit_clear = idle_like || (state_q == ST_ERR);
    assign store_ok  = !fifo_full && (byte_cnt_q != MAX_CNT);

    rx_bit_counter u_bit_counter (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear_i     (bit_clear),
        .enable_i    (shift_enable),
        .count_o     (bit_cnt),
        .byte_done_o (byte_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            rx_pid_q   <= 4'h0;
            byte_cnt_q <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_pid_q   <= rx_pid_d;
            byte_cnt_q <= byte_cnt_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR_IDLE: if (d_edge) state_d = ST_SYNC;
            ST_SYNC: begin
                if (eop)            state_d = ST_ERR;
                else if (byte_done) state_d = ST_CHK_SYNC;
            end
            ST_CHK_SYNC: state_d = (rcv_data == SYNC_BYTE) ? ST_PID : ST_ERR;
            ST_PID: begin
                if (eop)            state_d = ST_ERR;
                else if (byte_done) state_d = ST_CHK_PID;
            end
            ST_CHK_PID: state_d = pid_ok(rcv_data) ? ST_DATA : ST_ERR;
            // eop outranks byte_done: a byte finishing under SE0 is not a real byte.
            ST_DATA: begin
                if (eop)            state_d = (bit_cnt == 3'd0) ? ST_EOP_WAIT : ST_ERR;
                else if (byte_done) state_d = ST_STORE;
            end
            ST_STORE:    state_d = store_ok ? ST_DATA : ST_ERR;
            ST_EOP_WAIT: if (!eop) state_d = ST_IDLE;
            ST_ERR:      if (!eop) state_d = ST_ERR_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_pid_d   = rx_pid_q;
        byte_cnt_d = byte_cnt_q;
        pkt_done_d = (state_q == ST_EOP_WAIT) && !eop;
        if ((state_q == ST_CHK_PID) && pid_ok(rcv_data)) begin
            rx_pid_d = rcv_data[3:0];
        end
        if (idle_like && d_edge) begin
            byte_cnt_d = '0;
        end else if ((state_q == ST_STORE) && store_ok) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rcving   = !(idle_like || (state_q == ST_ERR));
        w_enable = (state_q == ST_STORE) && store_ok;
        r_error  = (state_q == ST_ERR) || (state_q == ST_ERR_IDLE);
    end

    assign rx_pid   = rx_pid_q;
    assign pkt_done = pkt_done_q;
`ifdef RX_BYTE_COUNT_EN
    assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb/tb_usb_rx_ctrl.sv - self-checking bench for usb_rx_ctrl (two instances, MAX_BYTES 64 and 4)
module tb_usb_rx_ctrl;

    localparam int CNT_W = 7;

    logic       clk = 1'b0;
    logic       n_rst, d_edge, shift_enable, eop, fifo_full;
    logic [7:0] rcv_data;

    logic       rcving_a, w_enable_a, r_error_a, pkt_done_a;
    logic       rcving_b, w_enable_b, r_error_b, pkt_done_b;
    logic [3:0] rx_pid_a, rx_pid_b;
`ifdef RX_BYTE_COUNT_EN
    logic [CNT_W-1:0] byte_cnt_a, byte_cnt_b;
`endif

    usb_rx_ctrl dut_a (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .shift_enable(shift_enable),
        .eop(eop), .rcv_data(rcv_data), .fifo_full(fifo_full),
        .rcving(rcving_a), .w_enable(w_enable_a), .r_error(r_error_a),
        .rx_pid(rx_pid_a), .pkt_done(pkt_done_a)
`ifdef RX_BYTE_COUNT_EN
        , .byte_cnt(byte_cnt_a)
`endif
    );

    usb_rx_ctrl #(.MAX_BYTES(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .shift_enable(shift_enable),
        .eop(eop), .rcv_data(rcv_data), .fifo_full(fifo_full),
        .rcving(rcving_b), .w_enable(w_enable_b), .r_error(r_error_b),
        .rx_pid(rx_pid_b), .pkt_done(pkt_done_b)
`ifdef RX_BYTE_COUNT_EN
        , .byte_cnt(byte_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int         wr_a = 0, wr_b = 0, done_a = 0, done_b = 0;
    logic [7:0] log_a [0:1023];
    logic [7:0] log_b [0:1023];

    always @(negedge clk) begin
        if (w_enable_a) begin
            log_a[wr_a % 1024] <= rcv_data;
            wr_a <= wr_a + 1;
        end
        if (w_enable_b) begin
            log_b[wr_b % 1024] <= rcv_data;
            wr_b <= wr_b + 1;
        end
        if (pkt_done_a) done_a <= done_a + 1;
        if (pkt_done_b) done_b <= done_b + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Packet under test
    logic [7:0] p_sync, p_pid;
    logic [7:0] p_data [0:7];
    int         p_n, p_part, p_full;
    logic [3:0] exp_pid;

    typedef struct {
        logic [7:0] sync;
        logic [7:0] pid;
        int         n;
        int         part;
        int         full;
        int         wa;
        int         wb;
        bit         ea;
        bit         eb;
        bit         da;
        bit         db;
        logic [3:0] epid;
    } vec_t;

    vec_t vecs [0:7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rcv_data     = {b, rcv_data[7:1]};
        shift_enable = 1'b1;
        step(1);
        shift_enable = 1'b0;
        step(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
        step(1);
    endtask

    task automatic send_eop();
        eop = 1'b1;
        step(2);
        eop = 1'b0;
        step(4);
    endtask

    // Packet-level reference: header validity, then the first payload byte that
    // hits a full FIFO or the byte limit ends the packet with an error.
    function automatic bit hdr_ok();
        return (p_sync == 8'h80) && (p_pid[3:0] == ~p_pid[7:4]);
    endfunction

    function automatic int model_writes(input int maxb);
        if (!hdr_ok()) return 0;
        for (int i = 0; i < p_n; i++) begin
            if (i == p_full || i >= maxb) return i;
        end
        return p_n;
    endfunction

    function automatic bit model_err(input int maxb);
        return !hdr_ok() || (model_writes(maxb) < p_n) || (p_part != 0);
    endfunction

    task automatic check_packet(input string tag, input int base_a, input int base_b,
                                input int dba, input int dbb, input int wa, input int wb,
                                input bit ea, input bit eb, input bit da, input bit db);
        int bad;
        check({tag, ".writes_a"}, wr_a - base_a, wa);
        check({tag, ".writes_b"}, wr_b - base_b, wb);
        bad = 0;
        for (int i = 0; i < wa && i < wr_a - base_a; i++)
            if (log_a[(base_a + i) % 1024] != p_data[i]) bad++;
        for (int i = 0; i < wb && i < wr_b - base_b; i++)
            if (log_b[(base_b + i) % 1024] != p_data[i]) bad++;
        check({tag, ".data_bad"}, bad, 0);
        check({tag, ".r_error_a"}, int'(r_error_a), int'(ea));
        check({tag, ".r_error_b"}, int'(r_error_b), int'(eb));
        check({tag, ".done_a"}, done_a - dba, int'(da));
        check({tag, ".done_b"}, done_b - dbb, int'(db));
        check({tag, ".rx_pid_a"}, int'(rx_pid_a), int'(exp_pid));
        check({tag, ".rx_pid_b"}, int'(rx_pid_b), int'(exp_pid));
        check({tag, ".rcving"}, int'(rcving_a | rcving_b), 0);
`ifdef RX_BYTE_COUNT_EN
        check({tag, ".byte_cnt_a"}, int'(byte_cnt_a), wa);
        check({tag, ".byte_cnt_b"}, int'(byte_cnt_b), wb);
`endif
    endtask

    task automatic run_packet(output int base_a, output int base_b, output int dba, output int dbb);
        base_a = wr_a;
        base_b = wr_b;
        dba    = done_a;
        dbb    = done_b;
        pulse_edge();
        send_byte(p_sync);
        send_byte(p_pid);
        for (int i = 0; i < p_n; i++) begin
            fifo_full = (i == p_full);
            send_byte(p_data[i]);
            fifo_full = 1'b0;
        end
        for (int i = 0; i < p_part; i++) send_bit(1'($urandom_range(0, 1)));
        send_eop();
    endtask

    initial begin
        int ba, bb, da, db;
        logic [3:0] nib;

        vecs[0] = '{8'h80, 8'hC3, 3, 0, -1, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};
        vecs[1] = '{8'h81, 8'hC3, 2, 0, -1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3};
        vecs[2] = '{8'h80, 8'hC4, 2, 0, -1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3};
        vecs[3] = '{8'h80, 8'h4B, 2, 5, -1, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 4'hB};
        vecs[4] = '{8'h80, 8'hD2, 0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2};
        vecs[5] = '{8'h80, 8'hC3, 3, 0,  1, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3};
        vecs[6] = '{8'h80, 8'h4B, 5, 0, -1, 5, 4, 1'b0, 1'b1, 1'b1, 1'b0, 4'hB};
        vecs[7] = '{8'h80, 8'hE1, 4, 0, -1, 4, 4, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1};

        n_rst = 1'b0; d_edge = 1'b0; shift_enable = 1'b0; eop = 1'b0;
        fifo_full = 1'b0; rcv_data = 8'h00;
        step(3);
        check("reset.rcving", int'(rcving_a | rcving_b), 0);
        check("reset.w_enable", int'(w_enable_a | w_enable_b), 0);
        check("reset.r_error", int'(r_error_a | r_error_b), 0);
        check("reset.pkt_done", int'(pkt_done_a | pkt_done_b), 0);
        check("reset.rx_pid", int'({rx_pid_a, rx_pid_b}), 0);
        n_rst = 1'b1;
        step(2);
        check("idle.rcving", int'(rcving_a), 0);
        exp_pid = 4'h0;

        for (int v = 0; v < 8; v++) begin
            p_sync = vecs[v].sync; p_pid = vecs[v].pid; p_n = vecs[v].n;
            p_part = vecs[v].part; p_full = vecs[v].full;
            for (int i = 0; i < 8; i++) p_data[i] = 8'(8'h11 * (i + 1));
            exp_pid = vecs[v].epid;
            run_packet(ba, bb, da, db);
            check_packet($sformatf("vec%0d", v), ba, bb, da, db, vecs[v].wa, vecs[v].wb,
                         vecs[v].ea, vecs[v].eb, vecs[v].da, vecs[v].db);
        end

        // Sticky r_error until the next d_edge
        p_sync = 8'h81; p_pid = 8'hC3; p_n = 1; p_part = 0; p_full = -1;
        run_packet(ba, bb, da, db);
        step(10);
        check("sticky.r_error_held", int'(r_error_a), 1);
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
        check("sticky.r_error_cleared", int'(r_error_a), 0);
        check("sticky.rcving", int'(rcving_a), 1);
        da = done_a;
        send_byte(8'h80);
        send_byte(8'hC3);
        send_eop();
        exp_pid = 4'h3;
        check("sticky.done", done_a - da, 1);
        check("sticky.rx_pid", int'(rx_pid_a), int'(exp_pid));

        // byte_done coinciding with eop in DATA
        ba = wr_a; da = done_a;
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        for (int i = 0; i < 7; i++) send_bit(1'(i & 1));
        rcv_data = {1'b1, rcv_data[7:1]};
        shift_enable = 1'b1;
        eop = 1'b1;
        step(1);
        shift_enable = 1'b0;
        step(2);
        eop = 1'b0;
        step(4);
        check("eop_race.writes", wr_a - ba, 0);
        check("eop_race.r_error", int'(r_error_a), 1);
        check("eop_race.done", done_a - da, 0);

        // Randomized packets against the packet-level model
        for (int r = 0; r < 24; r++) begin
            p_sync = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h80;
            nib = 4'($urandom);
            p_pid = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {~nib, nib};
            p_n = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) p_data[i] = 8'($urandom);
            p_part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            p_full = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            if (hdr_ok()) exp_pid = p_pid[3:0];
            run_packet(ba, bb, da, db);
            check_packet($sformatf("rnd%0d", r), ba, bb, da, db,
                         model_writes(64), model_writes(4), model_err(64), model_err(4),
                         !model_err(64), !model_err(4));
        end

        // Reset asserted mid-DATA
        ba = wr_a; bb = wr_b;
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_mid.rcving", int'(rcving_a | rcving_b), 0);
        check("rst_mid.w_enable", int'(w_enable_a | w_enable_b), 0);
        check("rst_mid.rx_pid", int'({rx_pid_a, rx_pid_b}), 0);
        check("rst_mid.r_error", int'(r_error_a | r_error_b), 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        check("rst_mid.no_write", (wr_a - ba) + (wr_b - bb), 0);
        n_rst = 1'b1;
        step(3);
        check("rst_mid.idle", int'(rcving_a | pkt_done_a | r_error_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
